// File: rtl/spindle_ctrl.sv
// Spindle motor sequencer: spin-up delay, index-period lock detection and index watchdog.
// Optional feature macro SPIN_OFF_DELAY_EN adds a COAST state that keeps the spindle running after motor-off.
`timescale 1ns/1ps
module spindle_ctrl #(
  parameter int CNT_W         = 24,
  parameter int SPINUP_CYC    = 10_000_000,
  parameter int PER_300       = 4_000_000,
  parameter int PER_360       = 3_333_333,
  parameter int TOL_CYC       = 40_000,
  parameter int LOCK_REVS     = 2,
  parameter int OFF_DELAY_CYC = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic motor_on,
  input  logic dens_sel,
  input  logic index_in,
  output logic spin_en,
  output logic spin_ss,
  output logic ready,
  output logic fault
);

  localparam logic [CNT_W-1:0] TGT_300     = CNT_W'(PER_300);
  localparam logic [CNT_W-1:0] TGT_360     = CNT_W'(PER_360);
  localparam logic [CNT_W-1:0] TOL         = CNT_W'(TOL_CYC);
  localparam logic [CNT_W-1:0] SPINUP_LAST = CNT_W'(SPINUP_CYC - 1);
  localparam logic [7:0]       REVS        = 8'(LOCK_REVS);

  // Both delays share one counter, so each must fit in CNT_W bits.
  if (SPINUP_CYC > (1 << CNT_W) || OFF_DELAY_CYC > (1 << CNT_W)) begin : g_width_chk
    $error("spindle_ctrl: delay parameter exceeds CNT_W");
  end

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_SPINUP = 3'd1,
    S_LOCK   = 3'd2,
    S_READY  = 3'd3,
    S_FAULT  = 3'd4,
    S_COAST  = 3'd5
  } state_t;

  state_t           state;
  logic [1:0]       motor_sync;
  logic [1:0]       dens_sync;
  logic [1:0]       idx_sync;
  logic             idx_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] dly;
  logic [7:0]       good;
  logic             armed;

  logic             motor_off;
  logic             dens_s;
  logic             idx_edge;
  logic             dens_chg;
  logic             measuring;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] diff;
  logic [CNT_W:0]   wd_lim;
  logic             in_tol;
  logic             wd_hit;

  // motor_on is active-low, so its synchronizer resets to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_sync <= 2'b11;
      dens_sync  <= 2'b00;
      idx_sync   <= 2'b00;
      idx_d      <= 1'b0;
    end else begin
      motor_sync <= {motor_sync[0], motor_on};
      dens_sync  <= {dens_sync[0], dens_sel};
      idx_sync   <= {idx_sync[0], index_in};
      idx_d      <= idx_sync[1];
    end
  end

  assign motor_off = motor_sync[1];
  assign dens_s    = dens_sync[1];
  assign idx_edge  = idx_sync[1] & ~idx_d;
  assign dens_chg  = dens_s != spin_ss;
  assign measuring = (state == S_LOCK) || (state == S_READY) || (state == S_COAST);
  assign target    = spin_ss ? TGT_360 : TGT_300;
  assign diff      = (per_cnt >= target) ? (per_cnt - target) : (target - per_cnt);
  assign in_tol    = diff <= TOL;
  // Fires on the edge where the count would reach twice the target.
  assign wd_lim    = {target, 1'b0} - 1'b1;
  assign wd_hit    = ({1'b0, per_cnt} >= wd_lim) && !idx_edge;

  // Period counter only runs while measuring, so LOCK entry starts a fresh watchdog window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!measuring || idx_edge) begin
      per_cnt <= '0;
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OFF;
      spin_en <= 1'b0;
      spin_ss <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      dly     <= '0;
      good    <= '0;
      armed   <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          spin_en <= 1'b0;
          ready   <= 1'b0;
          if (!motor_off) begin
            state   <= S_SPINUP;
            spin_en <= 1'b1;
            spin_ss <= dens_s;
            dly     <= '0;
          end
        end
        S_SPINUP: begin
          if (motor_off) begin
            state   <= S_OFF;
            spin_en <= 1'b0;
          end else begin
            if (dens_chg) spin_ss <= dens_s;
            if (dly == SPINUP_LAST) begin
              state <= S_LOCK;
              good  <= '0;
              armed <= 1'b0;
            end else begin
              dly <= dly + 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (motor_off) begin
            state   <= S_OFF;
            spin_en <= 1'b0;
          end else if (wd_hit) begin
            state   <= S_FAULT;
            spin_en <= 1'b0;
            fault   <= 1'b1;
          end else if (dens_chg) begin
            spin_ss <= dens_s;
            good    <= '0;
            armed   <= 1'b0;
          end else if (idx_edge) begin
            if (!armed) begin
              armed <= 1'b1;
            end else if (in_tol) begin
              good <= good + 8'd1;
              if (good + 8'd1 >= REVS) begin
                state <= S_READY;
                ready <= 1'b1;
              end
            end else begin
              good <= '0;
            end
          end
        end
        S_READY: begin
          if (motor_off) begin
`ifdef SPIN_OFF_DELAY_EN
            state <= S_COAST;
            dly   <= '0;
`else
            state   <= S_OFF;
            spin_en <= 1'b0;
            ready   <= 1'b0;
`endif
          end else if (wd_hit) begin
            state   <= S_FAULT;
            spin_en <= 1'b0;
            ready   <= 1'b0;
            fault   <= 1'b1;
          end else if (dens_chg) begin
            state   <= S_LOCK;
            ready   <= 1'b0;
            spin_ss <= dens_s;
            good    <= '0;
            armed   <= 1'b0;
          end else if (idx_edge && !in_tol) begin
            // The failing edge is still a valid reference, so measurement stays armed.
            state <= S_LOCK;
            ready <= 1'b0;
            good  <= '0;
          end
        end
`ifdef SPIN_OFF_DELAY_EN
        S_COAST: begin
          if (wd_hit) begin
            state   <= S_FAULT;
            spin_en <= 1'b0;
            ready   <= 1'b0;
            fault   <= 1'b1;
          end else if (dens_chg) begin
            state   <= S_LOCK;
            ready   <= 1'b0;
            spin_ss <= dens_s;
            good    <= '0;
            armed   <= 1'b0;
          end else if (!motor_off) begin
            state <= S_READY;
          end else if (dly == CNT_W'(OFF_DELAY_CYC - 1)) begin
            state   <= S_OFF;
            spin_en <= 1'b0;
            ready   <= 1'b0;
          end else begin
            dly <= dly + 1'b1;
          end
        end
`endif
        S_FAULT: begin
          spin_en <= 1'b0;
          ready   <= 1'b0;
          if (motor_off) begin
            state <= S_OFF;
            fault <= 1'b0;
          end
        end
        default: begin
          state   <= S_OFF;
          spin_en <= 1'b0;
          ready   <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spindle_ctrl.sv
// Self-checking bench for spindle_ctrl: randomized index trains against a pulse-level lock model.
`timescale 1ns/1ps
module tb_spindle_ctrl;

  localparam int SPINUP = 100;
  localparam int T300   = 1000;
  localparam int T360   = 833;
  localparam int TOL    = 20;
  localparam int REVS   = 2;
  localparam int OFFD   = 200;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic motor_on = 1'b1;
  logic dens_sel = 1'b0;
  logic index_in = 1'b0;
  logic spin_en, spin_ss, ready, fault;

  int errors = 0;
  int checks = 0;

  // Pulse-level model: selected speed, arming, consecutive good periods, lock flag.
  bit m_ss;
  bit m_armed;
  int m_good;
  bit m_ready;
  int used;

  always #5 clk = ~clk;

  spindle_ctrl #(
    .CNT_W(24), .SPINUP_CYC(SPINUP), .PER_300(T300), .PER_360(T360),
    .TOL_CYC(TOL), .LOCK_REVS(REVS), .OFF_DELAY_CYC(OFFD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_on(motor_on), .dens_sel(dens_sel),
    .index_in(index_in), .spin_en(spin_en), .spin_ss(spin_ss),
    .ready(ready), .fault(fault)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_restart(input bit ss);
    m_ss = ss; m_armed = 0; m_good = 0; m_ready = 0; used = 0;
  endtask

  // mode 0: in-tolerance gaps, 1: out-of-tolerance gaps, 2: random mix
  task automatic pulse_train(input int n, input int mode, input string name);
    for (int k = 0; k < n; k++) begin
      int tgt, p, dev, sel;
      tgt = m_ss ? T360 : T300;
      sel = (mode == 2) ? int'($urandom_range(1, 0)) : mode;
      if (sel == 0) begin
        p = tgt - 15 + int'($urandom_range(30, 0));
      end else begin
        dev = int'($urandom_range(60, 30));
        p = ($urandom_range(1, 0) == 1) ? tgt + dev : tgt - dev;
      end
      tick(p - 7 - used);
      used = 0;
      checks++;
      if (ready !== m_ready) begin
        errors++;
        $display("FAIL %s_pre[%0d]: ready=%b expected %b (gap %0d)", name, k, ready, m_ready, p);
      end
      tick(1);
      index_in = 1'b1;
      if (!m_armed) begin
        m_armed = 1;
      end else if (((p > tgt) ? p - tgt : tgt - p) <= TOL) begin
        m_good++;
        if (m_good >= REVS) m_ready = 1;
      end else begin
        m_good = 0;
        m_ready = 0;
      end
      tick(3);
      index_in = 1'b0;
      tick(3);
      checks++;
      if (ready !== m_ready || spin_en !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL %s_post[%0d]: ready=%b spin_en=%b fault=%b expected %b 1 0 (gap %0d)",
                 name, k, ready, spin_en, fault, m_ready, p);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; motor_on = 1'b1; dens_sel = 1'b0; index_in = 1'b0;
    tick(3);
    checks++;
    if ({spin_en, spin_ss, ready, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {spin_en, spin_ss, ready, fault});
    end
    rst_n = 1'b1;
    tick(10);
    checks++;
    if ({spin_en, spin_ss, ready, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected 0000", {spin_en, spin_ss, ready, fault});
    end
  endtask

  task automatic test_spinup;
    dens_sel = 1'b0;
    motor_on = 1'b0;
    model_restart(1'b0);
    tick(2);
    checks++;
    if (spin_en !== 1'b0) begin
      errors++;
      $display("FAIL spinup_edge2: spin_en=%b expected 0", spin_en);
    end
    tick(1);
    checks++;
    if (spin_en !== 1'b1 || spin_ss !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL spinup_edge3: spin_en=%b spin_ss=%b ready=%b expected 1 0 0", spin_en, spin_ss, ready);
    end
    tick(SPINUP + 10);
    checks++;
    if (spin_en !== 1'b1 || ready !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL spinup_done: spin_en=%b ready=%b fault=%b expected 1 0 0", spin_en, ready, fault);
    end
  endtask

  task automatic test_lock;
    pulse_train(4, 0, "lock_300");
    pulse_train(4, 1, "off_tol_300");
    pulse_train(3, 0, "relock_300");
  endtask

  task automatic test_random_mix;
    pulse_train(10, 2, "mix_300");
    pulse_train(3, 0, "settle_300");
  endtask

  task automatic test_speed_change;
    dens_sel = 1'b1;
    tick(2);
    checks++;
    if (spin_ss !== 1'b0) begin
      errors++;
      $display("FAIL speed_edge2: spin_ss=%b expected 0", spin_ss);
    end
    tick(1);
    checks++;
    if (spin_ss !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL speed_edge3: spin_ss=%b ready=%b expected 1 0", spin_ss, ready);
    end
    m_ss = 1; m_armed = 0; m_good = 0; m_ready = 0;
    used = 3;
    pulse_train(4, 0, "lock_360");
  endtask

  task automatic test_watchdog;
    int t2;
    t2 = 2 * (m_ss ? T360 : T300);
    tick(t2 - 13);
    checks++;
    if (fault !== 1'b0 || spin_en !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: fault=%b spin_en=%b expected 0 1", fault, spin_en);
    end
    tick(20);
    checks++;
    if (fault !== 1'b1 || spin_en !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL wd_fire: fault=%b spin_en=%b ready=%b expected 1 0 0", fault, spin_en, ready);
    end
    motor_on = 1'b1;
    tick(2);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: fault=%b expected 1", fault);
    end
    tick(1);
    checks++;
    if (fault !== 1'b0 || spin_en !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: fault=%b spin_en=%b expected 0 0", fault, spin_en);
    end
  endtask

  task automatic test_off_delay;
    dens_sel = 1'b0;
    tick(5);
    motor_on = 1'b0;
    model_restart(1'b0);
    tick(SPINUP + 13);
    pulse_train(3, 0, "lock_off");
`ifdef SPIN_OFF_DELAY_EN
    begin
      bit held;
      held = 1;
      motor_on = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick(1);
        if (ready !== 1'b1) held = 0;
      end
      motor_on = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (ready !== 1'b1) held = 0;
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL coast_return: ready dropped, expected held 1");
      end
      motor_on = 1'b1;
      tick(195);
      checks++;
      if (spin_en !== 1'b1 || ready !== 1'b1) begin
        errors++;
        $display("FAIL coast_hold: spin_en=%b ready=%b expected 1 1", spin_en, ready);
      end
      tick(15);
      checks++;
      if (spin_en !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL coast_expire: spin_en=%b ready=%b expected 0 0", spin_en, ready);
      end
    end
`else
    motor_on = 1'b1;
    tick(2);
    checks++;
    if (spin_en !== 1'b1) begin
      errors++;
      $display("FAIL off_edge2: spin_en=%b expected 1", spin_en);
    end
    tick(1);
    checks++;
    if (spin_en !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL off_edge3: spin_en=%b ready=%b expected 0 0", spin_en, ready);
    end
`endif
  endtask

  task automatic test_reset_mid;
    motor_on = 1'b0;
    tick(SPINUP + 20);
    checks++;
    if (spin_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: spin_en=%b expected 1", spin_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spin_en, spin_ss, ready, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected 0000", {spin_en, spin_ss, ready, fault});
    end
    tick(2);
    motor_on = 1'b1;
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (spin_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: spin_en=%b expected 0", spin_en);
    end
  endtask

  initial begin
    test_reset();
    test_spinup();
    test_lock();
    test_random_mix();
    test_speed_change();
    test_watchdog();
    test_off_delay();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
